// File: rtl/ins_pipe_if.sv
// Bundle between fetch/control (master) and the instruction-register pipeline (slave).
// Carries the fetched word, flush request, stage IRs, decoded fields, PCs and counters.
interface ins_pipe_if;
  logic [31:0] imem_ins;
  logic [31:0] fetch_pc;
  logic        stall_decode;

  logic [31:0] ins1, ins2, ins3, ins4;
  logic [6:0]  opcode1, opcode2, opcode3, opcode4;
  logic [4:0]  ins2_rs1, ins2_rs2;
  logic [4:0]  ins3_rd, ins3_rs2;
  logic [4:0]  ins4_rd;
  logic [31:0] pc2, pc4;
  logic        fetch_hold;
  logic [15:0] bubble_count, flush_count;

  modport master (
    output imem_ins, fetch_pc, stall_decode,
    input  ins1, ins2, ins3, ins4,
    input  opcode1, opcode2, opcode3, opcode4,
    input  ins2_rs1, ins2_rs2, ins3_rd, ins3_rs2, ins4_rd,
    input  pc2, pc4, fetch_hold, bubble_count, flush_count
  );

  modport slave (
    input  imem_ins, fetch_pc, stall_decode,
    output ins1, ins2, ins3, ins4,
    output opcode1, opcode2, opcode3, opcode4,
    output ins2_rs1, ins2_rs2, ins3_rd, ins3_rs2, ins4_rd,
    output pc2, pc4, fetch_hold, bubble_count, flush_count
  );
endinterface

// File: rtl/ins_pipe.sv
// Four-stage RISC-V instruction-register pipeline: advances IR/PC pairs, inserts a
// one-cycle load-use bubble, and squashes decode/execute on a control-flow flush.
module ins_pipe (
  input logic       clk,
  input logic       reset,
  ins_pipe_if.slave bus
);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;

  logic [31:0] ins1_q, ins2_q, ins3_q, ins4_q;
  logic [31:0] ins1_d, ins2_d, ins3_d, ins4_d;
  logic [31:0] pc1_q, pc2_q, pc3_q, pc4_q;
  logic [31:0] pc1_d, pc2_d, pc3_d, pc4_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        hazard;
  logic        flush;
  logic        ins1_uses_rs;

  // U-type and jal carry no source registers, so their rs fields are immediate bits.
  always_comb begin
    ins1_uses_rs = (ins1_q[6:0] != OP_LUI) && (ins1_q[6:0] != OP_AUIPC) &&
                   (ins1_q[6:0] != OP_JAL);
    hazard = (ins2_q[6:0] == OP_LOAD) && (ins2_q[11:7] != 5'd0) && ins1_uses_rs &&
             ((ins1_q[19:15] == ins2_q[11:7]) || (ins1_q[24:20] == ins2_q[11:7]));
  end

  assign flush = bus.stall_decode;

  always_comb begin
    ins1_d       = bus.imem_ins;
    pc1_d        = bus.fetch_pc;
    ins2_d       = ins1_q;
    pc2_d        = pc1_q;
    ins3_d       = ins2_q;
    pc3_d        = pc2_q;
    ins4_d       = ins3_q;
    pc4_d        = pc3_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (flush) begin
      ins1_d      = NOP;
      pc1_d       = 32'd0;
      ins2_d      = NOP;
      pc2_d       = 32'd0;
      flush_cnt_d = flush_cnt_q + 16'd1;
    end else if (hazard) begin
      ins1_d       = ins1_q;
      pc1_d        = pc1_q;
      ins2_d       = NOP;
      pc2_d        = 32'd0;
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ins1_q       <= NOP;
      ins2_q       <= NOP;
      ins3_q       <= NOP;
      ins4_q       <= NOP;
      pc1_q        <= 32'd0;
      pc2_q        <= 32'd0;
      pc3_q        <= 32'd0;
      pc4_q        <= 32'd0;
      bubble_cnt_q <= 16'd0;
      flush_cnt_q  <= 16'd0;
    end else begin
      ins1_q       <= ins1_d;
      ins2_q       <= ins2_d;
      ins3_q       <= ins3_d;
      ins4_q       <= ins4_d;
      pc1_q        <= pc1_d;
      pc2_q        <= pc2_d;
      pc3_q        <= pc3_d;
      pc4_q        <= pc4_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.ins1         = ins1_q;
  assign bus.ins2         = ins2_q;
  assign bus.ins3         = ins3_q;
  assign bus.ins4         = ins4_q;
  assign bus.opcode1      = ins1_q[6:0];
  assign bus.opcode2      = ins2_q[6:0];
  assign bus.opcode3      = ins3_q[6:0];
  assign bus.opcode4      = ins4_q[6:0];
  assign bus.ins2_rs1     = ins2_q[19:15];
  assign bus.ins2_rs2     = ins2_q[24:20];
  assign bus.ins3_rd      = ins3_q[11:7];
  assign bus.ins3_rs2     = ins3_q[24:20];
  assign bus.ins4_rd      = ins4_q[11:7];
  assign bus.pc2          = pc2_q;
  assign bus.pc4          = pc4_q;
  assign bus.fetch_hold   = hazard && !flush;
  assign bus.bubble_count = bubble_cnt_q;
  assign bus.flush_count  = flush_cnt_q;
endmodule

// File: doc/ins_pipe.md
INS_PIPE -- requirements
Module: ins_pipe

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 imem_ins  input  32  instruction word fetched this cycle, destined for stage 1 (decode).
REQ-004 fetch_pc  input  32  PC of imem_ins.
REQ-005 stall_decode  input  1  flush request from control (jal/jalr in stage 2 or taken branch).
REQ-006 ins1, ins2, ins3, ins4  output  32 each  instruction registers of decode, execute, memory and writeback stages.
REQ-007 opcode1..opcode4  output  7 each  bits [6:0] of ins1..ins4.
REQ-008 ins2_rs1, ins2_rs2  output  5 each  ins2[19:15], ins2[24:20].
REQ-009 ins3_rd, ins3_rs2  output  5 each  ins3[11:7], ins3[24:20].
REQ-010 ins4_rd  output  5  ins4[11:7].
REQ-011 pc2, pc4  output  32 each  PC carried with ins2 and ins4.
REQ-012 fetch_hold  output  1  1 = PC register and imem fetch hold current value this cycle.
REQ-013 bubble_count, flush_count  output  16 each  wrapping event counters.

Function
REQ-014 Field outputs (REQ-007..010) shall be purely combinational slices of the stage registers.
REQ-015 NOP shall be 32'h00000013 (addi x0,x0,0); every bubble inserted shall be exactly this word with PC 0.
REQ-016 Normal advance (no flush, no hazard): ins4<=ins3, ins3<=ins2, ins2<=ins1, ins1<=imem_ins; PCs move in lockstep (pc1<=fetch_pc).
REQ-017 Load-use hazard = opcode2==7'b0000011 and ins2 rd!=0 and opcode1 not in {0110111, 0010111, 1101111} and (ins1 rs1==ins2 rd or ins1 rs2==ins2 rd).
REQ-018 On hazard (no flush): ins1/pc1 hold, ins2<=NOP, ins3/ins4 advance, fetch_hold=1 same cycle, bubble_count increments.
REQ-019 Hazard stall shall last exactly one cycle; next cycle the load is in stage 3 and hazard deasserts by construction.
REQ-020 On stall_decode=1: ins1<=NOP, ins2<=NOP, ins3<=ins2, ins4<=ins3, fetch_hold=0, flush_count increments.
REQ-021 Flush shall take priority over hazard when both are true in the same cycle; bubble_count shall not increment then.
REQ-022 fetch_hold shall be combinational: hazard and not stall_decode.
REQ-023 Counters shall wrap 16'hFFFF -> 16'h0000 with no flag.
REQ-024 Back-to-back flushes on consecutive cycles shall each squash and each count.
REQ-025 No state other than the four IR/PC pairs and two counters.

Reset
REQ-026 While reset=1, ins1..ins4 = NOP, pc1..pc4 = 0, counters = 0, fetch_hold = 0, independent of clk.
REQ-027 Reset deasserted mid-stream: first rising edge after release shall load imem_ins into ins1 per REQ-016; reset asserted mid-stall shall abandon the stall immediately.

Verification
REQ-028 Reset then 4 cycles of imem_ins=A,B,C,D (no hazards) -> ins4=A, ins3=B, ins2=C, ins1=D; opcode fields match slices.
REQ-029 ins2=lw x5,0(x1), ins1=add x6,x5,x7 -> fetch_hold=1 that cycle; next edge ins2=NOP, ins1 unchanged, ins3=lw, bubble_count=1.
REQ-030 ins2=lw x0,0(x1), ins1=add x6,x0,x7 -> no stall, bubble_count stays 0.
REQ-031 stall_decode=1 with ins2=beq, ins1=X -> next edge ins1=ins2=NOP, ins3=beq, flush_count=1.
REQ-032 Load-use condition plus stall_decode=1 simultaneously -> flush behaviour only, fetch_hold=0, bubble_count unchanged.
REQ-033 Preload flush_count=16'hFFFF via 65535 flushes, one more -> 16'h0000; assert reset asynchronously mid-cycle -> all IRs NOP before next edge.
